status_register: RTL and testbench
==================================

# status_register

Processor status register (P) for the cpu6502 core: holds the N, V, D, I, Z and C flags. It sits directly downstream of the ALU and captures the ALU carry output (ACR), the overflow signal (AVR), and flag values derived from the internal data bus (DB). It also synchronises the external SO (set overflow) pin, and drives P onto DB for PHP, BRK and interrupt pushes.

## Interface
- No parameters.
- i_clk  input  1  CPU clock (phi2); all state updates on its falling edge.
- i_reset_n  input  1  reset, asynchronous, active-low.
- i_db  input  8  internal data bus value.
- i_db_p  input  1  load all flags from DB (PLP/RTI); bits 5 and 4 of DB are ignored.
- i_db0_c, i_db1_z, i_db2_i, i_db3_d, i_db6_v, i_db7_n  input  1 each  load the named flag from the named DB bit.
- i_dbz_z  input  1  Z <= (i_db == 8'h00).
- i_acr, i_acr_c  input  1, 1  ALU carry value; C <= i_acr when i_acr_c is high.
- i_avr, i_avr_v  input  1, 1  ALU overflow value; V <= i_avr when i_avr_v is high.
- i_ir5, i_ir5_c, i_ir5_i, i_ir5_d  input  1 each  set/clear value (opcode bit 5) for CLC/SEC, CLI/SEI and CLD/SED.
- i_0_v  input  1  clear V (CLV).
- i_1_i  input  1  set I (interrupt/BRK entry).
- i_so_n  input  1  external SO pin, asynchronous, active-low, falling-edge sensitive.
- i_p_db  input  1  drive P onto o_db.
- i_brk  input  1  bit-4 value for a push: 1 for BRK/PHP, 0 for IRQ/NMI.
- o_p  output  8  {N,V,1,1,D,I,Z,C}.
- o_db  output  8  {N,V,1,i_brk,D,I,Z,C} when i_p_db is high, otherwise 8'hFF.

## Operation
- Six flag flops: N, V, D, I, Z, C. Bits 5 and 4 are not stored.
- i_db_p acts as if all six DB-bit loads (i_db0_c, i_db1_z, i_db2_i, i_db3_d, i_db6_v, i_db7_n) were asserted together.
- Per-flag priority, highest first. A flag with no active source holds its value.
  - C: i_ir5_c > i_acr_c > DB bit 0.
  - Z: DB bit 1 > i_dbz_z.
  - I: i_1_i > i_ir5_i > DB bit 2.
  - D: i_ir5_d > DB bit 3.
  - V: i_0_v > i_avr_v > DB bit 6 > SO event.
  - N: DB bit 7.
- SO path:
  - i_so_n passes through a 2-flop synchroniser clocked on the falling edge, then a history flop.
  - An SO event is raised when the history flop is 1 and the synchroniser output is 0 (a falling edge).
  - The event sets V = 1 on the same edge on which it is detected.
  - If any higher-priority V source is active on that edge, the explicit write wins and the SO event is discarded, not deferred.
  - A held-low SO produces exactly one event.
- o_db is combinational from the flag flops, i_brk and i_p_db.
- o_p is combinational from the flag flops.

## Timing
- Reset (asynchronous assert):
  - N = V = D = Z = C = 0, I = 1, so o_p = 8'h34.
  - Synchroniser and history flops reset to 1, so no spurious SO event.
  - o_db = 8'hFF unless i_p_db is high.
- Deassertion of i_reset_n takes effect from the next falling edge.
- Flag loads: control and data inputs are sampled on the falling edge; the new value is visible on o_p immediately after that edge. Latency is 1 edge.
- i_acr_c: i_acr must be stable before the falling edge. It is captured on the same edge on which the ALU latches ADD.
- SO latency: 3 falling edges from the i_so_n fall to V = 1 (2 synchroniser edges plus 1 detect edge).
- i_so_n pulses shorter than 2 clock periods are not guaranteed to be detected.
- o_db and o_p are combinational; there is no latency from i_p_db or i_brk.
- Reset asserted mid-operation overrides all pending loads and any pending SO event.

## Test plan
- Reset: pulse i_reset_n low with no clock edges -> o_p = 8'h34; o_db = 8'hFF; with i_p_db = 1 and i_brk = 0, o_db = 8'h24.
- PLP: i_db = 8'hCF, i_db_p = 1, one falling edge -> o_p = 8'hFF; then i_db = 8'h00, one edge -> o_p = 8'h30.
- Priority conflict: i_acr = 1, i_acr_c = 1, i_ir5 = 0, i_ir5_c = 1 -> C = 0; i_0_v = 1 with i_avr = 1, i_avr_v = 1 -> V = 0.
- SO path:
  - Drop i_so_n at an edge -> V = 1 exactly 3 falling edges later.
  - Hold low for 10 edges -> only one event; clear V with i_0_v -> V stays 0.
  - An SO event on the same edge as i_avr_v = 1, i_avr = 0 -> V = 0 and the event is discarded.
- Zero/negative load: i_db = 8'h00 with i_dbz_z = 1 and i_db7_n = 1 -> Z = 1, N = 0; i_db = 8'h80 -> Z = 0, N = 1.
- Push image: flags N = 1, D = 1, C = 1, i_p_db = 1 -> o_db = 8'hB9 with i_brk = 1 and 8'hA9 with i_brk = 0; i_1_i = 1 for one edge -> I = 1 with the other flags unchanged.

Source files
------------

// File: rtl/status_register_if.sv
// Signal bundle between the cpu6502 datapath/control and the processor status register.
// The controller side (master) drives loads, bus value and push controls; the register (slave) returns P.
interface status_register_if;
  logic [7:0] i_db;
  logic       i_db_p;
  logic       i_db0_c;
  logic       i_db1_z;
  logic       i_db2_i;
  logic       i_db3_d;
  logic       i_db6_v;
  logic       i_db7_n;
  logic       i_dbz_z;
  logic       i_acr;
  logic       i_acr_c;
  logic       i_avr;
  logic       i_avr_v;
  logic       i_ir5;
  logic       i_ir5_c;
  logic       i_ir5_i;
  logic       i_ir5_d;
  logic       i_0_v;
  logic       i_1_i;
  logic       i_so_n;
  logic       i_p_db;
  logic       i_brk;
  logic [7:0] o_p;
  logic [7:0] o_db;

  modport master (
    output i_db, i_db_p, i_db0_c, i_db1_z, i_db2_i, i_db3_d, i_db6_v, i_db7_n,
           i_dbz_z, i_acr, i_acr_c, i_avr, i_avr_v, i_ir5, i_ir5_c, i_ir5_i,
           i_ir5_d, i_0_v, i_1_i, i_so_n, i_p_db, i_brk,
    input  o_p, o_db
  );

  modport slave (
    input  i_db, i_db_p, i_db0_c, i_db1_z, i_db2_i, i_db3_d, i_db6_v, i_db7_n,
           i_dbz_z, i_acr, i_acr_c, i_avr, i_avr_v, i_ir5, i_ir5_c, i_ir5_i,
           i_ir5_d, i_0_v, i_1_i, i_so_n, i_p_db, i_brk,
    output o_p, o_db
  );
endinterface

// File: rtl/status_register.sv
// 6502 processor status register: six flag flops updated on the falling edge of phi2,
// plus a synchronised falling-edge detector for the external SO pin.
module status_register (
  input  logic               i_clk,
  input  logic               i_reset_n,
  status_register_if.slave   bus
);
  logic flag_n, flag_v, flag_d, flag_i, flag_z, flag_c;
  logic next_n, next_v, next_d, next_i, next_z, next_c;
  logic so_sync1, so_sync2, so_hist;
  logic so_event;
  logic ld_c, ld_z, ld_i, ld_d, ld_v, ld_n;

  // PLP/RTI is just every DB-bit load at once.
  assign ld_c = bus.i_db0_c | bus.i_db_p;
  assign ld_z = bus.i_db1_z | bus.i_db_p;
  assign ld_i = bus.i_db2_i | bus.i_db_p;
  assign ld_d = bus.i_db3_d | bus.i_db_p;
  assign ld_v = bus.i_db6_v | bus.i_db_p;
  assign ld_n = bus.i_db7_n | bus.i_db_p;

  assign so_event = so_hist & ~so_sync2;

  always_comb begin
    next_c = flag_c;
    next_z = flag_z;
    next_i = flag_i;
    next_d = flag_d;
    next_v = flag_v;
    next_n = flag_n;

    if (bus.i_ir5_c)      next_c = bus.i_ir5;
    else if (bus.i_acr_c) next_c = bus.i_acr;
    else if (ld_c)        next_c = bus.i_db[0];

    if (ld_z)             next_z = bus.i_db[1];
    else if (bus.i_dbz_z) next_z = (bus.i_db == 8'h00);

    if (bus.i_1_i)        next_i = 1'b1;
    else if (bus.i_ir5_i) next_i = bus.i_ir5;
    else if (ld_i)        next_i = bus.i_db[2];

    if (bus.i_ir5_d)      next_d = bus.i_ir5;
    else if (ld_d)        next_d = bus.i_db[3];

    // An SO event losing to an explicit V write is dropped, since the history flop moves on regardless.
    if (bus.i_0_v)        next_v = 1'b0;
    else if (bus.i_avr_v) next_v = bus.i_avr;
    else if (ld_v)        next_v = bus.i_db[6];
    else if (so_event)    next_v = 1'b1;

    if (ld_n)             next_n = bus.i_db[7];
  end

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      flag_n   <= 1'b0;
      flag_v   <= 1'b0;
      flag_d   <= 1'b0;
      flag_i   <= 1'b1;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      so_sync1 <= 1'b1;
      so_sync2 <= 1'b1;
      so_hist  <= 1'b1;
    end else begin
      flag_n   <= next_n;
      flag_v   <= next_v;
      flag_d   <= next_d;
      flag_i   <= next_i;
      flag_z   <= next_z;
      flag_c   <= next_c;
      so_sync1 <= bus.i_so_n;
      so_sync2 <= so_sync1;
      so_hist  <= so_sync2;
    end
  end

  assign bus.o_p  = {flag_n, flag_v, 2'b11, flag_d, flag_i, flag_z, flag_c};
  assign bus.o_db = bus.i_p_db ? {flag_n, flag_v, 1'b1, bus.i_brk, flag_d, flag_i, flag_z, flag_c}
                               : 8'hFF;
endmodule

// File: tb/tb_status_register.sv
// Self-checking bench for status_register: directed scenarios then randomized traffic,
// all compared against a flag-level reference model.
module tb_status_register;
  logic clk;
  logic reset_n;
  status_register_if bus ();

  status_register dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus.slave)
  );

  // clock/reset
  initial clk = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state: P image and the last three SO pin samples (oldest in [2])
  logic [7:0] model_p;
  logic [2:0] model_so;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
  endtask

  task automatic clear_ctl();
    bus.i_db = 8'h00;   bus.i_db_p = 0;  bus.i_db0_c = 0; bus.i_db1_z = 0;
    bus.i_db2_i = 0;    bus.i_db3_d = 0; bus.i_db6_v = 0; bus.i_db7_n = 0;
    bus.i_dbz_z = 0;    bus.i_acr = 0;   bus.i_acr_c = 0; bus.i_avr = 0;
    bus.i_avr_v = 0;    bus.i_ir5 = 0;   bus.i_ir5_c = 0; bus.i_ir5_i = 0;
    bus.i_ir5_d = 0;    bus.i_0_v = 0;   bus.i_1_i = 0;
  endtask

  function automatic logic [7:0] push_image(input logic [7:0] p, input logic p_db, input logic brk);
    if (!p_db) return 8'hFF;
    return {p[7:6], 1'b1, brk, p[3:0]};
  endfunction

  // Each flag takes the first active source in its priority list.
  function automatic logic [7:0] model_next(input logic [7:0] p, input logic so_ev);
    logic [7:0] n;
    logic all;
    n   = p;
    all = bus.i_db_p;
    if (bus.i_ir5_c)               n[0] = bus.i_ir5;
    else if (bus.i_acr_c)          n[0] = bus.i_acr;
    else if (bus.i_db0_c || all)   n[0] = bus.i_db[0];
    if (bus.i_db1_z || all)        n[1] = bus.i_db[1];
    else if (bus.i_dbz_z)          n[1] = (bus.i_db == 0);
    if (bus.i_1_i)                 n[2] = 1;
    else if (bus.i_ir5_i)          n[2] = bus.i_ir5;
    else if (bus.i_db2_i || all)   n[2] = bus.i_db[2];
    if (bus.i_ir5_d)               n[3] = bus.i_ir5;
    else if (bus.i_db3_d || all)   n[3] = bus.i_db[3];
    if (bus.i_0_v)                 n[6] = 0;
    else if (bus.i_avr_v)          n[6] = bus.i_avr;
    else if (bus.i_db6_v || all)   n[6] = bus.i_db[6];
    else if (so_ev)                n[6] = 1;
    if (bus.i_db7_n || all)        n[7] = bus.i_db[7];
    return n;
  endfunction

  task automatic model_reset();
    model_p  = 8'h34;
    model_so = 3'b111;
  endtask

  // One falling edge: model consumes the same inputs the DUT samples, then outputs are compared.
  task automatic step(input string tag);
    logic ev;
    @(negedge clk);
    ev       = model_so[2] & ~model_so[1];
    model_p  = model_next(model_p, ev);
    model_so = {model_so[1:0], bus.i_so_n};
    #1;
    check({tag, "_p"},  bus.o_p,  model_p);
    check({tag, "_db"}, bus.o_db, push_image(model_p, bus.i_p_db, bus.i_brk));
  endtask

  task automatic do_reset();
    #2 reset_n = 0;
    model_reset();
    #1;
    check("rst_p",  bus.o_p,  8'h34);
    check("rst_db", bus.o_db, push_image(8'h34, bus.i_p_db, bus.i_brk));
    reset_n = 1;
  endtask

  initial begin
    clear_ctl();
    bus.i_so_n = 1; bus.i_p_db = 0; bus.i_brk = 0;
    reset_n = 1;
    model_reset();
    #3;

    // reset, no clock edge inside the pulse
    @(posedge clk); #1;
    reset_n = 0; #1;
    check("reset_p",  bus.o_p,  8'h34);
    check("reset_db", bus.o_db, 8'hFF);
    bus.i_p_db = 1; bus.i_brk = 0; #1;
    check("reset_push", bus.o_db, 8'h24);
    bus.i_p_db = 0;
    reset_n = 1;
    model_reset();

    // PLP
    bus.i_db = 8'hCF; bus.i_db_p = 1; step("plp_cf");
    check("plp_cf_const", bus.o_p, 8'hFF);
    bus.i_db = 8'h00; step("plp_00");
    check("plp_00_const", bus.o_p, 8'h30);
    clear_ctl();

    // priority conflicts (start from all flags set)
    bus.i_db = 8'hFF; bus.i_db_p = 1; step("pri_set"); clear_ctl();
    bus.i_acr = 1; bus.i_acr_c = 1; bus.i_ir5 = 0; bus.i_ir5_c = 1;
    bus.i_0_v = 1; bus.i_avr = 1; bus.i_avr_v = 1;
    step("pri");
    check("pri_c", {7'd0, bus.o_p[0]}, 8'd0);
    check("pri_v", {7'd0, bus.o_p[6]}, 8'd0);
    clear_ctl();

    // SO: latency of 3 edges, single event on a long low
    bus.i_so_n = 0;
    step("so_e1"); check("so_v_e1", {7'd0, bus.o_p[6]}, 8'd0);
    step("so_e2"); check("so_v_e2", {7'd0, bus.o_p[6]}, 8'd0);
    step("so_e3"); check("so_v_e3", {7'd0, bus.o_p[6]}, 8'd1);
    for (int k = 0; k < 7; k++) step("so_hold");
    bus.i_0_v = 1; step("so_clv"); bus.i_0_v = 0;
    for (int k = 0; k < 5; k++) step("so_after");
    check("so_one_event", {7'd0, bus.o_p[6]}, 8'd0);

    // SO event colliding with an AVR write is discarded
    bus.i_so_n = 1; for (int k = 0; k < 4; k++) step("so_rise");
    bus.i_so_n = 0; step("so2_e1"); step("so2_e2");
    bus.i_avr_v = 1; bus.i_avr = 0; step("so2_e3"); clear_ctl();
    check("so_discard", {7'd0, bus.o_p[6]}, 8'd0);
    for (int k = 0; k < 4; k++) step("so2_post");
    bus.i_so_n = 1;

    // zero / negative loads
    bus.i_db = 8'h00; bus.i_dbz_z = 1; bus.i_db7_n = 1; step("zn_00");
    check("zn_00_zn", {6'd0, bus.o_p[7], bus.o_p[1]}, 8'b01);
    bus.i_db = 8'h80; step("zn_80");
    check("zn_80_zn", {6'd0, bus.o_p[7], bus.o_p[1]}, 8'b10);
    clear_ctl();

    // push image
    bus.i_db = 8'h89; bus.i_db_p = 1; step("push_ld"); clear_ctl();
    bus.i_p_db = 1; bus.i_brk = 1; #1; check("push_brk", bus.o_db, 8'hB9);
    bus.i_brk = 0; #1;                check("push_irq", bus.o_db, 8'hA9);
    bus.i_1_i = 1; step("sei_int"); bus.i_1_i = 0;
    check("sei_int_p", bus.o_p, 8'hBD);
    bus.i_p_db = 0;

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      clear_ctl();
      bus.i_db = 8'($urandom_range(0, 255));
      bus.i_db_p  = ($urandom_range(0, 15) == 0);
      bus.i_db0_c = ($urandom_range(0, 5) == 0);
      bus.i_db1_z = ($urandom_range(0, 5) == 0);
      bus.i_db2_i = ($urandom_range(0, 5) == 0);
      bus.i_db3_d = ($urandom_range(0, 5) == 0);
      bus.i_db6_v = ($urandom_range(0, 7) == 0);
      bus.i_db7_n = ($urandom_range(0, 5) == 0);
      bus.i_dbz_z = ($urandom_range(0, 4) == 0);
      bus.i_acr   = 1'($urandom_range(0, 1));
      bus.i_acr_c = ($urandom_range(0, 4) == 0);
      bus.i_avr   = 1'($urandom_range(0, 1));
      bus.i_avr_v = ($urandom_range(0, 6) == 0);
      bus.i_ir5   = 1'($urandom_range(0, 1));
      bus.i_ir5_c = ($urandom_range(0, 6) == 0);
      bus.i_ir5_i = ($urandom_range(0, 6) == 0);
      bus.i_ir5_d = ($urandom_range(0, 6) == 0);
      bus.i_0_v   = ($urandom_range(0, 9) == 0);
      bus.i_1_i   = ($urandom_range(0, 9) == 0);
      bus.i_p_db  = 1'($urandom_range(0, 1));
      bus.i_brk   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) bus.i_so_n = ~bus.i_so_n;
      if ($urandom_range(0, 150) == 0) do_reset();
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
